// File: rtl/exc_ctrl.sv
// exc_ctrl: CP0 subset exception/interrupt controller for the five-stage pipeline.
// Decides whether the MEM-stage exception, interrupt or ERET is taken this cycle.
// Owns the Status/Cause/EPC/Count/Compare registers and the timer interrupt.
module exc_ctrl (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [5:0]  i_int_req,
    input  logic        i_MEM_valid,
    input  logic        i_MEM_stall,
    input  logic [31:0] i_MEM_pc,
    input  logic        i_MEM_in_delay_slot,
    input  logic        i_MEM_exc_valid,
    input  logic [4:0]  i_MEM_exc_cause,
    input  logic        i_MEM_is_eret,
    input  logic        i_cp0_we,
    input  logic [4:0]  i_cp0_waddr,
    input  logic [31:0] i_cp0_wdata,
    input  logic [4:0]  i_cp0_raddr,
    output logic [31:0] o_cp0_rdata,
    output logic        o_answer_exc,
    output logic [4:0]  o_exception_cause,
    output logic        o_is_eret,
    output logic [31:0] o_epc_value,
    output logic        o_flush
);

    localparam logic [4:0] ExcCauseInt = 5'd0;

    localparam logic [4:0] RegCount   = 5'd9;
    localparam logic [4:0] RegCompare = 5'd11;
    localparam logic [4:0] RegStatus  = 5'd12;
    localparam logic [4:0] RegCause   = 5'd13;
    localparam logic [4:0] RegEpc     = 5'd14;

    typedef enum logic {StRun, StBlock} state_t;

    state_t      r_state;
    state_t      w_state_d;

    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_timer_pending;
    logic        r_ie;
    logic        r_exl;
    logic [7:0]  r_im;
    logic        r_bd;
    logic [1:0]  r_ip_sw;
    logic [4:0]  r_exccode;
    logic [31:0] r_epc;
    logic [5:0]  r_sync1;
    logic [5:0]  r_sync2;

    logic [7:0]  w_ip;
    logic        w_mem_ok;
    logic        w_int;
    logic        w_answer;
    logic        w_eret;
    logic [4:0]  w_cause;
    logic        w_flush;
    logic        w_cp0_wr;
    logic [31:0] w_status;
    logic [31:0] w_cause_reg;

    // Pending-event view, the taken-event decision and MTC0 squash.
    always_comb begin
        w_ip        = {r_sync2[5] | r_timer_pending, r_sync2[4:0], r_ip_sw};
        // Reset discards anything the MEM stage presents in the same cycle.
        w_mem_ok    = !i_rst && (r_state == StRun) && i_MEM_valid && !i_MEM_stall;
        w_int       = w_mem_ok && r_ie && !r_exl && ((w_ip & r_im) != 8'd0);
        w_answer    = w_int || (w_mem_ok && i_MEM_exc_valid);
        w_eret      = w_mem_ok && i_MEM_is_eret && !w_answer;
        w_cause     = 5'd0;
        if (w_answer) begin
            w_cause = w_int ? ExcCauseInt : i_MEM_exc_cause;
        end
        w_flush     = w_answer || w_eret;
        // The MEM instruction is squashed when an event is taken, so its MTC0 is too.
        w_cp0_wr    = i_cp0_we && !w_flush;
        w_status    = {16'd0, r_im, 6'd0, r_exl, r_ie};
        w_cause_reg = {r_bd, 15'd0, w_ip, 1'b0, r_exccode, 2'b00};
    end

    // Outputs and MFC0 read mux.
    always_comb begin
        o_answer_exc      = w_answer;
        o_exception_cause = w_cause;
        o_is_eret         = w_eret;
        o_flush           = w_flush;
        o_epc_value       = r_epc;
        o_cp0_rdata       = 32'd0;
        case (i_cp0_raddr)
            RegCount:   o_cp0_rdata = r_count;
            RegCompare: o_cp0_rdata = r_compare;
            RegStatus:  o_cp0_rdata = w_status;
            RegCause:   o_cp0_rdata = w_cause_reg;
            RegEpc:     o_cp0_rdata = r_epc;
            default:    o_cp0_rdata = 32'd0;
        endcase
    end

    // Next state: each taken event or ERET is followed by one blocked cycle.
    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StRun:   if (w_flush) w_state_d = StBlock;
            StBlock: w_state_d = StRun;
            default: w_state_d = StRun;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StRun;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Two-flop synchroniser for the asynchronous interrupt lines.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 6'd0;
            r_sync2 <= 6'd0;
        end else begin
            r_sync1 <= i_int_req;
            r_sync2 <= r_sync1;
        end
    end

    // Count/Compare timer; a Compare write acknowledges the timer interrupt.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count         <= 32'd0;
            r_compare       <= 32'hFFFF_FFFF;
            r_timer_pending <= 1'b0;
        end else begin
            if (w_cp0_wr && (i_cp0_waddr == RegCount)) begin
                r_count <= i_cp0_wdata;
            end else begin
                r_count <= r_count + 32'd1;
            end
            if (w_cp0_wr && (i_cp0_waddr == RegCompare)) begin
                r_compare       <= i_cp0_wdata;
                r_timer_pending <= 1'b0;
            end else if (r_count == r_compare) begin
                r_timer_pending <= 1'b1;
            end
        end
    end

    // Status/Cause/EPC: MTC0 writes, exception entry and ERET.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ie      <= 1'b0;
            r_exl     <= 1'b0;
            r_im      <= 8'd0;
            r_bd      <= 1'b0;
            r_ip_sw   <= 2'd0;
            r_exccode <= 5'd0;
            r_epc     <= 32'd0;
        end else begin
            if (w_cp0_wr && (i_cp0_waddr == RegStatus)) begin
                r_ie  <= i_cp0_wdata[0];
                r_exl <= i_cp0_wdata[1];
                r_im  <= i_cp0_wdata[15:8];
            end
            if (w_cp0_wr && (i_cp0_waddr == RegCause)) begin
                r_ip_sw <= i_cp0_wdata[9:8];
            end
            if (w_cp0_wr && (i_cp0_waddr == RegEpc)) begin
                r_epc <= i_cp0_wdata;
            end
            if (w_answer) begin
                r_exccode <= w_cause;
                r_exl     <= 1'b1;
                // A nested exception keeps the original return point.
                if (!r_exl) begin
                    r_epc <= i_MEM_in_delay_slot ? (i_MEM_pc - 32'd4) : i_MEM_pc;
                    r_bd  <= i_MEM_in_delay_slot;
                end
            end else if (w_eret) begin
                r_exl <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed self-checking bench for exc_ctrl.
module tb_exc_ctrl;

    logic        i_clk;
    logic        i_rst;
    logic [5:0]  i_int_req;
    logic        i_MEM_valid;
    logic        i_MEM_stall;
    logic [31:0] i_MEM_pc;
    logic        i_MEM_in_delay_slot;
    logic        i_MEM_exc_valid;
    logic [4:0]  i_MEM_exc_cause;
    logic        i_MEM_is_eret;
    logic        i_cp0_we;
    logic [4:0]  i_cp0_waddr;
    logic [31:0] i_cp0_wdata;
    logic [4:0]  i_cp0_raddr;
    logic [31:0] o_cp0_rdata;
    logic        o_answer_exc;
    logic [4:0]  o_exception_cause;
    logic        o_is_eret;
    logic [31:0] o_epc_value;
    logic        o_flush;

    int n_vec;
    int n_err;
    logic [31:0] rd;

    exc_ctrl u_dut (
        .i_clk               (i_clk),
        .i_rst               (i_rst),
        .i_int_req           (i_int_req),
        .i_MEM_valid         (i_MEM_valid),
        .i_MEM_stall         (i_MEM_stall),
        .i_MEM_pc            (i_MEM_pc),
        .i_MEM_in_delay_slot (i_MEM_in_delay_slot),
        .i_MEM_exc_valid     (i_MEM_exc_valid),
        .i_MEM_exc_cause     (i_MEM_exc_cause),
        .i_MEM_is_eret       (i_MEM_is_eret),
        .i_cp0_we            (i_cp0_we),
        .i_cp0_waddr         (i_cp0_waddr),
        .i_cp0_wdata         (i_cp0_wdata),
        .i_cp0_raddr         (i_cp0_raddr),
        .o_cp0_rdata         (o_cp0_rdata),
        .o_answer_exc        (o_answer_exc),
        .o_exception_cause   (o_exception_cause),
        .o_is_eret           (o_is_eret),
        .o_epc_value         (o_epc_value),
        .o_flush             (o_flush)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Advance one cycle; inputs change 1 ns after the rising edge.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_MEM_valid         = 1'b0;
        i_MEM_stall         = 1'b0;
        i_MEM_pc            = 32'd0;
        i_MEM_in_delay_slot = 1'b0;
        i_MEM_exc_valid     = 1'b0;
        i_MEM_exc_cause     = 5'd0;
        i_MEM_is_eret       = 1'b0;
        i_cp0_we            = 1'b0;
        i_cp0_waddr         = 5'd0;
        i_cp0_wdata         = 32'd0;
    endtask

    task automatic cp0_read(input logic [4:0] addr, output logic [31:0] data);
        i_cp0_raddr = addr;
        #1;
        data = o_cp0_rdata;
    endtask

    task automatic cp0_write(input logic [4:0] addr, input logic [31:0] data);
        i_cp0_we    = 1'b1;
        i_cp0_waddr = addr;
        i_cp0_wdata = data;
        tick();
        i_cp0_we    = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        idle_inputs();
        i_int_req   = 6'd0;
        i_cp0_raddr = 5'd0;
        tick();
        tick();
        n_vec++;
        if (o_flush !== 1'b0 || o_answer_exc !== 1'b0) begin
            $display("FAIL reset_outputs: flush=%b answer=%b want 0/0", o_flush, o_answer_exc);
            n_err++;
        end
        i_rst = 1'b0;
        cp0_read(5'd9, rd);
        n_vec++;
        if (rd !== 32'd0) begin
            $display("FAIL reset_count: got %h want 00000000", rd); n_err++;
        end
        cp0_read(5'd12, rd);
        n_vec++;
        if (rd !== 32'd0) begin
            $display("FAIL reset_status: got %h want 00000000", rd); n_err++;
        end
        cp0_read(5'd13, rd);
        n_vec++;
        if (rd !== 32'd0) begin
            $display("FAIL reset_cause: got %h want 00000000", rd); n_err++;
        end
        cp0_read(5'd14, rd);
        n_vec++;
        if (rd !== 32'd0 || o_epc_value !== 32'd0) begin
            $display("FAIL reset_epc: got %h/%h want 00000000", rd, o_epc_value); n_err++;
        end
        cp0_read(5'd11, rd);
        n_vec++;
        if (rd !== 32'hFFFF_FFFF) begin
            $display("FAIL reset_compare: got %h want ffffffff", rd); n_err++;
        end
        cp0_read(5'd3, rd);
        n_vec++;
        if (rd !== 32'd0) begin
            $display("FAIL unmapped_read: got %h want 00000000", rd); n_err++;
        end
        tick();
    endtask

    task automatic test_sync_exc();
        i_MEM_valid     = 1'b1;
        i_MEM_pc        = 32'h100;
        i_MEM_exc_valid = 1'b1;
        i_MEM_exc_cause = 5'd8;
        #1;
        n_vec++;
        if (o_answer_exc !== 1'b1 || o_exception_cause !== 5'd8 || o_flush !== 1'b1) begin
            $display("FAIL sys_answer: answer=%b cause=%0d flush=%b want 1/8/1",
                     o_answer_exc, o_exception_cause, o_flush);
            n_err++;
        end
        tick();
        // Still presenting the exception: the blocked cycle must ignore it.
        n_vec++;
        if (o_flush !== 1'b0 || o_answer_exc !== 1'b0) begin
            $display("FAIL sys_block: flush=%b answer=%b want 0/0", o_flush, o_answer_exc);
            n_err++;
        end
        idle_inputs();
        cp0_read(5'd14, rd);
        n_vec++;
        if (rd !== 32'h100) begin
            $display("FAIL sys_epc: got %h want 00000100", rd); n_err++;
        end
        cp0_read(5'd12, rd);
        n_vec++;
        if (rd !== 32'h2) begin
            $display("FAIL sys_status: got %h want 00000002", rd); n_err++;
        end
        cp0_read(5'd13, rd);
        n_vec++;
        if (rd !== 32'h20) begin
            $display("FAIL sys_cause: got %h want 00000020", rd); n_err++;
        end
        tick();
    endtask

    task automatic test_delay_slot_eret();
        cp0_write(5'd12, 32'd0);
        i_MEM_valid         = 1'b1;
        i_MEM_pc            = 32'h204;
        i_MEM_in_delay_slot = 1'b1;
        i_MEM_exc_valid     = 1'b1;
        i_MEM_exc_cause     = 5'd12;
        #1;
        n_vec++;
        if (o_answer_exc !== 1'b1 || o_exception_cause !== 5'd12) begin
            $display("FAIL ov_answer: answer=%b cause=%0d want 1/12",
                     o_answer_exc, o_exception_cause);
            n_err++;
        end
        tick();
        idle_inputs();
        cp0_read(5'd14, rd);
        n_vec++;
        if (rd !== 32'h200) begin
            $display("FAIL ov_epc: got %h want 00000200", rd); n_err++;
        end
        cp0_read(5'd13, rd);
        n_vec++;
        if (rd !== 32'h8000_0030) begin
            $display("FAIL ov_cause: got %h want 80000030", rd); n_err++;
        end
        tick();
        i_MEM_valid   = 1'b1;
        i_MEM_pc      = 32'h208;
        i_MEM_is_eret = 1'b1;
        #1;
        n_vec++;
        if (o_is_eret !== 1'b1 || o_flush !== 1'b1 || o_answer_exc !== 1'b0 ||
            o_epc_value !== 32'h200) begin
            $display("FAIL eret: is_eret=%b flush=%b answer=%b epc=%h want 1/1/0/00000200",
                     o_is_eret, o_flush, o_answer_exc, o_epc_value);
            n_err++;
        end
        tick();
        idle_inputs();
        cp0_read(5'd12, rd);
        n_vec++;
        if (rd !== 32'h0) begin
            $display("FAIL eret_status: got %h want 00000000", rd); n_err++;
        end
        tick();
    endtask

    task automatic test_interrupt();
        cp0_write(5'd12, 32'h401);
        i_int_req   = 6'b000001;
        i_MEM_valid = 1'b1;
        i_MEM_pc    = 32'h300;
        #1;
        n_vec++;
        if (o_answer_exc !== 1'b0) begin
            $display("FAIL int_early0: answer=%b want 0", o_answer_exc); n_err++;
        end
        tick();
        n_vec++;
        if (o_answer_exc !== 1'b0) begin
            $display("FAIL int_early1: answer=%b want 0", o_answer_exc); n_err++;
        end
        tick();
        n_vec++;
        if (o_answer_exc !== 1'b1 || o_exception_cause !== 5'd0) begin
            $display("FAIL int_answer: answer=%b cause=%0d want 1/0",
                     o_answer_exc, o_exception_cause);
            n_err++;
        end
        i_MEM_stall = 1'b1;
        #1;
        n_vec++;
        if (o_answer_exc !== 1'b0 || o_flush !== 1'b0) begin
            $display("FAIL int_stall0: answer=%b flush=%b want 0/0", o_answer_exc, o_flush);
            n_err++;
        end
        tick();
        n_vec++;
        if (o_answer_exc !== 1'b0) begin
            $display("FAIL int_stall1: answer=%b want 0", o_answer_exc); n_err++;
        end
        // First unstalled cycle, with a competing RI and an MTC0 EPC that must be dropped.
        i_MEM_stall     = 1'b0;
        i_MEM_exc_valid = 1'b1;
        i_MEM_exc_cause = 5'd10;
        i_cp0_we        = 1'b1;
        i_cp0_waddr     = 5'd14;
        i_cp0_wdata     = 32'hDEAD_0000;
        #1;
        n_vec++;
        if (o_answer_exc !== 1'b1 || o_exception_cause !== 5'd0) begin
            $display("FAIL int_vs_ri: answer=%b cause=%0d want 1/0",
                     o_answer_exc, o_exception_cause);
            n_err++;
        end
        tick();
        idle_inputs();
        cp0_read(5'd14, rd);
        n_vec++;
        if (rd !== 32'h300) begin
            $display("FAIL int_epc: got %h want 00000300", rd); n_err++;
        end
        cp0_read(5'd13, rd);
        n_vec++;
        if (rd !== 32'h400) begin
            $display("FAIL int_cause: got %h want 00000400", rd); n_err++;
        end
        cp0_read(5'd12, rd);
        n_vec++;
        if (rd !== 32'h403) begin
            $display("FAIL int_status: got %h want 00000403", rd); n_err++;
        end
        tick();
    endtask

    task automatic test_nested();
        // EXL=1, IE=1, interrupt still pending: must be suppressed.
        i_MEM_valid = 1'b1;
        i_MEM_pc    = 32'h500;
        #1;
        n_vec++;
        if (o_answer_exc !== 1'b0) begin
            $display("FAIL exl_masks_int: answer=%b want 0", o_answer_exc); n_err++;
        end
        i_MEM_in_delay_slot = 1'b1;
        i_MEM_exc_valid     = 1'b1;
        i_MEM_exc_cause     = 5'd9;
        #1;
        n_vec++;
        if (o_answer_exc !== 1'b1 || o_exception_cause !== 5'd9) begin
            $display("FAIL nested_answer: answer=%b cause=%0d want 1/9",
                     o_answer_exc, o_exception_cause);
            n_err++;
        end
        tick();
        idle_inputs();
        cp0_read(5'd14, rd);
        n_vec++;
        if (rd !== 32'h300) begin
            $display("FAIL nested_epc: got %h want 00000300", rd); n_err++;
        end
        cp0_read(5'd13, rd);
        n_vec++;
        if (rd !== 32'h424) begin
            $display("FAIL nested_cause: got %h want 00000424", rd); n_err++;
        end
        i_int_req = 6'd0;
        tick();
        tick();
        tick();
        cp0_write(5'd12, 32'd0);
        tick();
    endtask

    task automatic test_timer();
        cp0_write(5'd11, 32'd10);
        cp0_write(5'd9, 32'd5);
        cp0_read(5'd9, rd);
        n_vec++;
        if (rd !== 32'd5) begin
            $display("FAIL count_write: got %h want 00000005", rd); n_err++;
        end
        for (int i = 1; i <= 6; i++) begin
            tick();
            cp0_read(5'd13, rd);
            n_vec++;
            if (rd[15] !== (i == 6)) begin
                $display("FAIL timer_ip7_c%0d: got %b want %b", i, rd[15], (i == 6));
                n_err++;
            end
        end
        cp0_write(5'd11, 32'h1000);
        cp0_read(5'd13, rd);
        n_vec++;
        if (rd[15] !== 1'b0) begin
            $display("FAIL timer_clear: got %b want 0", rd[15]); n_err++;
        end
        tick();
    endtask

    task automatic test_reset_mid();
        cp0_write(5'd12, 32'h0000_FF01);
        i_MEM_valid     = 1'b1;
        i_MEM_pc        = 32'h700;
        i_MEM_exc_valid = 1'b1;
        i_MEM_exc_cause = 5'd8;
        i_rst           = 1'b1;
        #1;
        n_vec++;
        if (o_answer_exc !== 1'b0 || o_flush !== 1'b0) begin
            $display("FAIL rst_mid_answer: answer=%b flush=%b want 0/0", o_answer_exc, o_flush);
            n_err++;
        end
        tick();
        i_rst = 1'b0;
        idle_inputs();
        cp0_read(5'd12, rd);
        n_vec++;
        if (rd !== 32'd0) begin
            $display("FAIL rst_mid_status: got %h want 00000000", rd); n_err++;
        end
        cp0_read(5'd11, rd);
        n_vec++;
        if (rd !== 32'hFFFF_FFFF) begin
            $display("FAIL rst_mid_compare: got %h want ffffffff", rd); n_err++;
        end
        cp0_read(5'd14, rd);
        n_vec++;
        if (rd !== 32'd0) begin
            $display("FAIL rst_mid_epc: got %h want 00000000", rd); n_err++;
        end
        // Back in RUN: a fresh exception is answered straight away.
        i_MEM_valid     = 1'b1;
        i_MEM_exc_valid = 1'b1;
        i_MEM_exc_cause = 5'd13;
        #1;
        n_vec++;
        if (o_answer_exc !== 1'b1 || o_exception_cause !== 5'd13) begin
            $display("FAIL rst_mid_run: answer=%b cause=%0d want 1/13",
                     o_answer_exc, o_exception_cause);
            n_err++;
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_sync_exc();
        test_delay_slot_eret();
        test_interrupt();
        test_nested();
        test_timer();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/exc_ctrl.md
# exc_ctrl

Exception and interrupt controller (CP0 subset) for the five-stage pipeline. It evaluates the MEM-stage exception/ERET status against the Status/Cause state and decides whether the exception is answered. It drives the answer, cause and EPC values consumed by next-PC selection, together with the pipeline flush. It also owns the Status, Cause, EPC, Count and Compare registers and the timer interrupt.

## Interface
- EXC_CAUSE_INT = 5'd0; ADEL = 4, ADES = 5, SYS = 8, BP = 9, RI = 10, OV = 12, TRAP = 13: ExcCode values, taken from `Exception.v`.
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_int_req  in  6  asynchronous hardware interrupt levels, mapped to IP[7:2].
- i_MEM_valid  in  1  MEM holds a real instruction, not a bubble.
- i_MEM_stall  in  1  MEM is stalled this cycle.
- i_MEM_pc  in  32  PC of the MEM instruction.
- i_MEM_in_delay_slot  in  1  MEM instruction sits in a branch delay slot.
- i_MEM_exc_valid  in  1  MEM instruction raised a synchronous exception.
- i_MEM_exc_cause  in  5  ExcCode of that exception.
- i_MEM_is_eret  in  1  MEM instruction is ERET.
- i_cp0_we  in  1  MTC0 write strobe from MEM.
- i_cp0_waddr  in  5  MTC0 register number.
- i_cp0_wdata  in  32  MTC0 data.
- i_cp0_raddr  in  5  MFC0 register number.
- o_cp0_rdata  out  32  combinational read data; returns 0 for unmapped registers.
- o_answer_exc  out  1  exception or interrupt is taken this cycle.
- o_exception_cause  out  5  ExcCode of the taken event.
- o_is_eret  out  1  ERET is honoured this cycle.
- o_epc_value  out  32  current EPC register value.
- o_flush  out  1  squash IF/ID/EX/MEM at the next edge.

## Operation
- CP0 registers:
  - Count (9); Compare (11).
  - Status (12): IE bit 0, EXL bit 1, IM bits 15:8, all other bits read as 0.
  - Cause (13): BD bit 31, IP bits 15:8, ExcCode bits 6:2. IP[1:0] are software-writable; IP[7:2] are read-only.
  - EPC (14).
- Interrupt synchronisation: i_int_req passes through 2 flops, giving hw_ip[5:0]. IP[7:2] = hw_ip, except IP[7] = hw_ip[5] | timer_pending.
- Timer:
  - Count increments by 1 every cycle and wraps FFFFFFFF to 0. An MTC0 write to Count overrides the increment.
  - When Count equals Compare, timer_pending is set at the next edge.
  - An MTC0 write to Compare clears timer_pending.
- Interrupt eligible when all of the following hold:
  - state is RUN;
  - IE = 1 and EXL = 0;
  - (IP & IM) is nonzero;
  - i_MEM_valid = 1 and i_MEM_stall = 0.
- Priority, evaluated combinationally in the cycle:
  1. Interrupt.
  2. Synchronous exception. Requires state RUN, i_MEM_valid = 1 and i_MEM_stall = 0.
  3. ERET. Requires state RUN, i_MEM_valid = 1 and i_MEM_stall = 0.
- Taken event (o_answer_exc = 1, o_flush = 1). At the edge:
  - ExcCode is set to the cause (INT for an interrupt).
  - EXL is set to 1.
  - If EXL was 0: EPC = i_MEM_pc − 4 and BD = 1 when in a delay slot; otherwise EPC = i_MEM_pc and BD = 0.
  - If EXL was already 1, EPC and BD are unchanged.
- ERET: o_is_eret = 1 and o_flush = 1; EXL is cleared at the edge.
- An MTC0 in the same cycle as a taken event or ERET is dropped: the MEM instruction is squashed. Otherwise MTC0 writes the register at the edge.
- o_exception_cause reflects the taken event while answering, and is 0 otherwise.
- FSM:
  - RUN: on a taken event or ERET, go to BLOCK.
  - BLOCK: one cycle in which no event is taken and o_flush = 0; then return to RUN.
  - Reset forces RUN.

## Timing
- Reset values:
  - All CP0 registers 0, except Compare = FFFFFFFF.
  - timer_pending = 0; synchroniser flops 0; state RUN.
  - All outputs 0.
- o_answer_exc, o_is_eret, o_flush and o_exception_cause are combinational from the current-cycle inputs and registered state. Register updates occur at the following edge.
- Interrupt latency: i_int_req rises before edge N, then IP is visible after edge N+1. The interrupt can be answered in the cycle after edge N+1, given eligibility.
- Timer: Count == Compare in cycle k, then IP[7] = 1 after edge k+1.
- Reset mid-operation: the pending answer is discarded and state is RUN in the next cycle.

## Test plan
- Reset, then read: Status = 0, Cause = 0, EPC = 0, Compare = FFFFFFFF, o_flush = 0.
- Synchronous exception, SYS at pc 0x100, not in delay slot, EXL = 0 → o_answer_exc = 1 and o_exception_cause = 8 in that cycle. After the edge: EPC = 0x100, EXL = 1, BD = 0. The next cycle is BLOCK, with o_flush = 0.
- OV at pc 0x204 in a delay slot → EPC = 0x200, BD = 1. Then ERET → o_is_eret = 1, o_epc_value = 0x200, and EXL = 0 after the edge.
- Hardware interrupt, IE = 1, IM[2] = 1: raise i_int_req[0] → answer with cause 0 two cycles later. With MEM stalled the answer waits and is taken on the first unstalled cycle. Simultaneously with an RI exception, cause = 0 (interrupt wins).
- Timer: write Compare = 10, Count = 5 → IP[7] set 6 cycles after the Count write. Writing Compare clears IP[7].
- Nested: sync exception while EXL = 1 → ExcCode updated, EPC unchanged; interrupts suppressed while EXL = 1.
